// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, branch flush and a saturating bubble counter
// Ports: *D inputs carry decoder control, register data and indices into E; PCSrcE is the taken branch/jump
// resolved in E. *E outputs hold the registered E-stage values and ValidE marks a real instruction there.
// StallF/StallD hold fetch and IF/ID, FlushD clears IF/ID, bubble_cnt counts inserted bubbles.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RegWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic [2:0]       ALUControlD,
  input  logic             ALUSrcD,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             PCSrcE,
  output logic             RegWriteE,
  output logic [1:0]       ResultSrcE,
  output logic             MemWriteE,
  output logic             JumpE,
  output logic             BranchE,
  output logic [2:0]       ALUControlE,
  output logic             ALUSrcE,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             ValidE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic [CNT_W-1:0] bubble_cnt
);
  localparam int EW = 5*XLEN + 26;
  logic lw_hit, lw_stall, flush_e;
  logic [EW-1:0] e_d;
  assign lw_hit   = ValidE & (ResultSrcE == 2'b01) & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
  // a taken branch kills the dependent decode instruction anyway, so it wins over the stall
  assign lw_stall = lw_hit & ~PCSrcE;
  assign flush_e  = lw_stall | PCSrcE;
  assign StallF   = lw_stall;
  assign StallD   = lw_stall;
  assign FlushD   = PCSrcE;
  assign e_d = flush_e ? '0 : {RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD, ALUSrcD,
                               RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD, 1'b1};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
       RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, ValidE} <= '0;
    else
      {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
       RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, ValidE} <= e_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bubble_cnt <= '0;
    else if (flush_e && bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline boundary for the 5-stage RV32 pipeline.
- Sits directly downstream of the instruction decoder.
- Registers decoder control outputs and decode-stage datapath values into the E stage.
- Owns load-use hazard detection and bubble/flush insertion, and counts inserted bubbles for performance debug.

Parameters:
XLEN, 32, datapath width of RD1/RD2/PC/immediate fields
CNT_W, 16, width of saturating bubble counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
RegWriteD  in  1  decoder register-write enable
ResultSrcD  in  2  decoder result select (01 = load)
MemWriteD  in  1  decoder store enable
JumpD  in  1  decoder jump flag
BranchD  in  1  decoder branch flag
ALUControlD  in  3  decoder ALU operation
ALUSrcD  in  1  decoder ALU B-operand select
RD1D, RD2D  in  XLEN  register-file read data
PCD, PCPlus4D, ImmExtD  in  XLEN  decode-stage PC, PC+4, extended immediate
Rs1D, Rs2D, RdD  in  5  register indices
PCSrcE  in  1  taken branch/jump resolved in E stage
RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE  out  same widths as D  registered control
RD1E, RD2E, PCE, PCPlus4E, ImmExtE  out  XLEN  registered data
Rs1E, Rs2E, RdE  out  5  registered indices
ValidE  out  1  E stage holds a real instruction
StallF, StallD  out  1  hold PC and IF/ID register
FlushD  out  1  clear IF/ID register
bubble_cnt  out  CNT_W  saturating count of bubbles inserted

Behaviour:
Reset
- rst_n low clears every registered output to 0 immediately (async), including ValidE and bubble_cnt.
- Release is synchronous to the next clk edge.
- Reset mid-stream discards the E-stage contents.

Hazard detection (combinational from current E regs and D inputs)
- lwHit = ValidE & (ResultSrcE==2'b01) & (RdE!=0) & ((RdE==Rs1D) | (RdE==Rs2D)).
- Rs1D/Rs2D are compared for every opcode; conservative stalls on U/jal are accepted.
- lwStall = lwHit & ~PCSrcE. A taken branch squashes the decode instruction, so no stall is needed.
- StallF = StallD = lwStall.
- FlushD = PCSrcE.
- FlushE = lwStall | PCSrcE.

Register update at each clk edge
- FlushE=1: all control outputs go to 0, all data/index outputs go to 0, and ValidE goes to 0 (bubble).
- Otherwise: all E outputs load their D inputs, and ValidE goes to 1.
- Latency: one cycle, D to E.
- The stage itself is never held: a stall always inserts a bubble downstream.

Bubble counter
- Increments by 1 on each edge where FlushE=1.
- Saturates at 2^CNT_W-1; no wrap-around.
- Cleared only by reset.

Simultaneous events
- PCSrcE with lwHit: flush only. StallF=StallD=0, FlushD=1, and one bubble is counted, not two.
- Back-to-back loads with dependent consumers: each dependency produces exactly one stall cycle.
- After a bubble, ValidE=0 blocks re-detection.

Test Plan:
1. Reset: drive all D inputs to nonzero, pulse rst_n low mid-cycle -> all outputs 0 immediately; after release with PCSrcE=0 and no hazard, next edge gives ValidE=1 and E = D values.
2. Load-use: lw x5 in E (ResultSrcE=01, RdE=5, ValidE=1), add with Rs1D=5 -> StallF=StallD=1; next edge E control all 0, ValidE=0, bubble_cnt=1; following edge the add enters E.
3. x0 destination: ResultSrcE=01, RdE=0, Rs2D=0 -> no stall, no bubble, bubble_cnt unchanged.
4. Branch flush: PCSrcE=1 with a non-load in E -> FlushD=1, StallF=0; next edge E cleared, ValidE=0, bubble_cnt+1.
5. Simultaneous: lwHit true and PCSrcE=1 -> StallF=StallD=0, FlushD=1; one bubble, counter +1 only.
6. Saturation with CNT_W=4: hold PCSrcE=1 for 20 cycles -> bubble_cnt reaches 15 and stays at 15.
